spatz_retire_unit: RTL

//  Completion side of the Spatz issue/response protocol. Allocates an instruction ID (spatz_id_t)
//  to each spatz_req_t the controller dispatches to LSU/SLD/VFU. Collects vfu_rsp_t, vlsu_rsp_t
//  and vsldu_rsp_t to free IDs. Buffers VFU scalar writebacks (rd/result) for the core.

---
 rtl/spatz_retire_unit_pkg.sv | 42 ++++
 rtl/spatz_retire_unit_fifo.sv | 51 +++++
 rtl/spatz_retire_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spatz_retire_unit_pkg.sv
// Shared types for the Spatz retire unit: instruction IDs, unit encoding,
// per-unit response records and the scalar writeback record.
package spatz_retire_unit_pkg;

  localparam int unsigned NrParallelInstructions = 4;
  localparam int unsigned NrWbCredits            = 2;
  localparam int unsigned GPRWidth               = 5;
  localparam int unsigned ELEN                   = 32;

  typedef logic [ELEN-1:0] elen_t;
  typedef logic [$clog2(NrParallelInstructions)-1:0] spatz_id_t;

  // CON is the controller itself and never owns an in-flight ID
  typedef enum logic [1:0] {
    CON = 2'd0,
    VFU = 2'd1,
    LSU = 2'd2,
    SLD = 2'd3
  } ex_unit_e;

  typedef struct packed {
    spatz_id_t           id;
    elen_t               result;
    logic [GPRWidth-1:0] rd;
    logic                wb;
  } vfu_rsp_t;

  typedef struct packed {
    spatz_id_t id;
    logic      exc;
  } vlsu_rsp_t;

  typedef struct packed {
    spatz_id_t id;
  } vsldu_rsp_t;

  typedef struct packed {
    logic [GPRWidth-1:0] rd;
    elen_t               data;
  } spatz_wb_t;

endpackage

// File: rtl/spatz_retire_unit_fifo.sv
// Registered (non fall-through) FIFO holding scalar writebacks until the
// core accepts them. Data pushed in cycle N is visible at the head in N+1.
module spatz_retire_unit_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         dtype = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  dtype                         data_i,
  input  logic                         pop_i,
  output dtype                         data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  dtype            mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  logic            push_eff, pop_eff;

  assign full_o   = (cnt_q == CW'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign usage_o  = cnt_q;
  assign data_o   = mem_q[rptr_q];
  assign push_eff = push_i && !full_o;
  assign pop_eff  = pop_i && !empty_o;

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_eff) wptr_q <= (wptr_q == AW'(DEPTH-1)) ? '0 : wptr_q + AW'(1);
      if (pop_eff)  rptr_q <= (rptr_q == AW'(DEPTH-1)) ? '0 : rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // storage needs no reset: an entry is only read after it was written
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/spatz_retire_unit.sv
// Completion side of the Spatz issue/response protocol: hands out instruction
// IDs, frees them on unit responses, reserves writeback buffer space at issue
// and buffers VFU scalar results for the core.
module spatz_retire_unit
  import spatz_retire_unit_pkg::*;
#(
  parameter int unsigned NrIds       = NrParallelInstructions,
  parameter int unsigned WbFifoDepth = NrWbCredits
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  ex_unit_e         issue_ex_unit_i,
  input  logic             issue_use_rd_i,
  output spatz_id_t        issue_id_o,
  input  logic             vfu_rsp_valid_i,
  output logic             vfu_rsp_ready_o,
  input  vfu_rsp_t         vfu_rsp_i,
  input  logic             vlsu_rsp_valid_i,
  input  vlsu_rsp_t        vlsu_rsp_i,
  input  logic             vsldu_rsp_valid_i,
  input  vsldu_rsp_t       vsldu_rsp_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output spatz_wb_t        wb_o,
  output logic             exc_valid_o,
  output spatz_id_t        exc_id_o,
  output logic [NrIds-1:0] id_busy_o,
  output logic             idle_o
);

  localparam int unsigned CrW = $clog2(WbFifoDepth+1);

  logic [NrIds-1:0] busy_q, busy_d;
  logic [NrIds-1:0] use_rd_q;
  ex_unit_e         unit_q [NrIds];
  logic [CrW-1:0]   credits_q;

  logic      any_free;
  spatz_id_t free_id;
  logic      issue_fire;
  logic      cr_take, cr_pop, cr_ret;

  logic      fifo_push, fifo_full, fifo_empty;
  spatz_wb_t fifo_din;
  logic [$clog2(WbFifoDepth+1)-1:0] fifo_usage;

  logic      exc_valid_q;
  spatz_id_t exc_id_q;

  // lowest free ID, scanning down so the smallest index wins
  always_comb begin
    free_id  = '0;
    any_free = 1'b0;
    for (int i = NrIds-1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_id  = spatz_id_t'(i);
        any_free = 1'b1;
      end
    end
  end

  // a writeback-producing instruction also needs a buffer credit
  assign issue_ready_o   = any_free && (!issue_use_rd_i || (credits_q != '0));
  assign issue_id_o      = free_id;
  assign issue_fire      = issue_valid_i && issue_ready_o;
  assign vfu_rsp_ready_o = 1'b1;

  // retires clear, then the new allocation sets; they never hit the same ID
  always_comb begin
    busy_d = busy_q;
    if (vfu_rsp_valid_i)   busy_d[vfu_rsp_i.id]   = 1'b0;
    if (vlsu_rsp_valid_i)  busy_d[vlsu_rsp_i.id]  = 1'b0;
    if (vsldu_rsp_valid_i) busy_d[vsldu_rsp_i.id] = 1'b0;
    if (issue_fire)        busy_d[free_id]        = 1'b1;
  end

  // per-ID ownership tracking
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q   <= '0;
      use_rd_q <= '0;
      for (int i = 0; i < NrIds; i++) unit_q[i] <= CON;
    end else begin
      busy_q <= busy_d;
      if (issue_fire) begin
        unit_q[free_id]   <= issue_ex_unit_i;
        use_rd_q[free_id] <= issue_use_rd_i;
      end
    end
  end

  // credit flow: taken at issue, returned on pop or on a VFU retire without wb
  assign cr_take = issue_fire && issue_use_rd_i;
  assign cr_pop  = wb_valid_o && wb_ready_i;
  assign cr_ret  = vfu_rsp_valid_i && !vfu_rsp_i.wb && use_rd_q[vfu_rsp_i.id];

  // credit counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) credits_q <= CrW'(WbFifoDepth);
    else         credits_q <= credits_q + CrW'(cr_pop) + CrW'(cr_ret) - CrW'(cr_take);
  end

  assign fifo_push = vfu_rsp_valid_i && vfu_rsp_i.wb;
  assign fifo_din  = '{rd: vfu_rsp_i.rd, data: vfu_rsp_i.result};

  spatz_retire_unit_fifo #(
    .DEPTH (WbFifoDepth),
    .dtype (spatz_wb_t)
  ) i_wb_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (fifo_din),
    .pop_i   (cr_pop),
    .data_o  (wb_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  assign wb_valid_o = !fifo_empty;

  // single-cycle exception report, one cycle after the VLSU response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exc_valid_q <= 1'b0;
      exc_id_q    <= '0;
    end else begin
      exc_valid_q <= vlsu_rsp_valid_i && vlsu_rsp_i.exc;
      if (vlsu_rsp_valid_i && vlsu_rsp_i.exc) exc_id_q <= vlsu_rsp_i.id;
    end
  end

  assign exc_valid_o = exc_valid_q;
  assign exc_id_o    = exc_id_q;
  assign id_busy_o   = busy_q;
  assign idle_o      = ~|busy_q && fifo_empty;

  // protocol violations from the controller or the units; no recovery is attempted
  a_vfu_busy:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                  vfu_rsp_valid_i |-> busy_q[vfu_rsp_i.id]);
  a_vlsu_busy:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                  vlsu_rsp_valid_i |-> busy_q[vlsu_rsp_i.id]);
  a_vsldu_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
                  vsldu_rsp_valid_i |-> busy_q[vsldu_rsp_i.id]);
  a_vfu_unit:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                  vfu_rsp_valid_i |-> unit_q[vfu_rsp_i.id] == VFU);
  a_vlsu_unit:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                  vlsu_rsp_valid_i |-> unit_q[vlsu_rsp_i.id] == LSU);
  a_vsldu_unit: assert property (@(posedge clk_i) disable iff (!rst_ni)
                  vsldu_rsp_valid_i |-> unit_q[vsldu_rsp_i.id] == SLD);
  a_dup_fl:     assert property (@(posedge clk_i) disable iff (!rst_ni)
                  (vfu_rsp_valid_i && vlsu_rsp_valid_i) |-> vfu_rsp_i.id != vlsu_rsp_i.id);
  a_dup_fs:     assert property (@(posedge clk_i) disable iff (!rst_ni)
                  (vfu_rsp_valid_i && vsldu_rsp_valid_i) |-> vfu_rsp_i.id != vsldu_rsp_i.id);
  a_dup_ls:     assert property (@(posedge clk_i) disable iff (!rst_ni)
                  (vlsu_rsp_valid_i && vsldu_rsp_valid_i) |-> vlsu_rsp_i.id != vsldu_rsp_i.id);
  a_issue_con:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                  issue_valid_i |-> issue_ex_unit_i != CON);
  a_wb_no_rd:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                  (vfu_rsp_valid_i && vfu_rsp_i.wb) |-> use_rd_q[vfu_rsp_i.id]);
  a_push_full:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                  fifo_push |-> !fifo_full || cr_pop);

endmodule
